// File: rtl/ahb_req_arbiter.sv
// Two-requester round-robin AHB-Lite master: one non-overlapping transfer at a time,
// with the result returned to the granted requester as a one-cycle ack.
module ahb_req_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  m0_req,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic                  m0_write,
    input  logic [2:0]            m0_size,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_ack,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_err,
    input  logic                  m1_req,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic                  m1_write,
    input  logic [2:0]            m1_size,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_ack,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_err,
    output logic                  HSEL,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [3:0]            HPROT,
    output logic [DATA_WIDTH-1:0] HWDATA,
    output logic                  HREADY,
    input  logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  HREADYOUT,
    input  logic                  HRESP
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_RESP
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic                  r_lastGrant;
    logic                  r_grant;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  w_anyReq;
    logic                  w_pickM1;

    assign HPROT  = 4'b0011;
    assign HREADY = HREADYOUT;

    // On a tie the port that did not win last time takes the bus.
    always_comb begin
        w_anyReq    = m0_req | m1_req;
        w_pickM1    = m1_req & (~m0_req | ~r_lastGrant);
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (w_anyReq) w_nextState = S_ADDR;
            S_ADDR:  w_nextState = S_DATA;
            S_DATA:  if (HREADYOUT) w_nextState = S_RESP;
            S_RESP:  w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) r_state <= S_IDLE;
        else        r_state <= w_nextState;
    end

    // HADDR/HWRITE/HSIZE double as the latched transfer register.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_lastGrant <= 1'b1;
            r_grant     <= 1'b0;
            r_wdata     <= '0;
            HSEL        <= 1'b0;
            HTRANS      <= 2'b00;
            HADDR       <= '0;
            HWRITE      <= 1'b0;
            HSIZE       <= 3'd0;
            HWDATA      <= '0;
            m0_ack      <= 1'b0;
            m1_ack      <= 1'b0;
            m0_err      <= 1'b0;
            m1_err      <= 1'b0;
            m0_rdata    <= '0;
            m1_rdata    <= '0;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_anyReq) begin
                        r_grant     <= w_pickM1;
                        r_lastGrant <= w_pickM1;
                        HSEL        <= 1'b1;
                        HTRANS      <= 2'b10;
                        HADDR       <= w_pickM1 ? m1_addr  : m0_addr;
                        HWRITE      <= w_pickM1 ? m1_write : m0_write;
                        HSIZE       <= w_pickM1 ? m1_size  : m0_size;
                        r_wdata     <= w_pickM1 ? m1_wdata : m0_wdata;
                    end
                end
                S_ADDR: begin
                    HSEL   <= 1'b0;
                    HTRANS <= 2'b00;
                    if (HWRITE) HWDATA <= r_wdata;
                end
                S_DATA: begin
                    if (HREADYOUT) begin
                        if (r_grant) begin
                            m1_rdata <= HRDATA;
                            m1_err   <= HRESP;
                            m1_ack   <= 1'b1;
                        end else begin
                            m0_rdata <= HRDATA;
                            m0_err   <= HRESP;
                            m0_ack   <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_req_arbiter.sv
// Directed bench for ahb_req_arbiter; the bench itself plays the AHB slave.
module tb_ahb_req_arbiter;

    logic        HCLK;
    logic        HRESET;
    logic        m0_req, m1_req;
    logic [15:0] m0_addr, m1_addr;
    logic        m0_write, m1_write;
    logic [2:0]  m0_size, m1_size;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_ack, m1_ack;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_err, m1_err;
    logic        HSEL;
    logic [15:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    int compared   = 0;
    int mismatched = 0;

    // Expected per-cycle bus activity for the simultaneous-request sequence.
    logic [1:0]  t3Trans [11] = '{2'd2, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0};
    logic        t3Ack0  [11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        t3Ack1  [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [15:0] t3Addr  [11] = '{16'h1C00, 16'h0, 16'h0, 16'h0, 16'h1000, 16'h0, 16'h0, 16'h0, 16'h1C00, 16'h0, 16'h0};

    ahb_req_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_write(m0_write), .m0_size(m0_size),
        .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_write(m1_write), .m1_size(m1_size),
        .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HPROT(HPROT), .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(negedge HCLK);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int port, input logic req, input logic [15:0] addr,
                                 input logic write, input logic [2:0] size, input logic [31:0] wdata);
        if (port == 0) begin
            m0_req = req; m0_addr = addr; m0_write = write; m0_size = size; m0_wdata = wdata;
        end else begin
            m1_req = req; m1_addr = addr; m1_write = write; m1_size = size; m1_wdata = wdata;
        end
    endtask

    initial begin
        HRESET = 1'b1; HREADYOUT = 1'b1; HRESP = 1'b0; HRDATA = '0;
        applyStimulus(0, 1'b0, 16'h0, 1'b0, 3'd0, 32'h0);
        applyStimulus(1, 1'b0, 16'h0, 1'b0, 3'd0, 32'h0);
        tick(); tick();
        checkOutput("rst_hsel", HSEL, 0);
        checkOutput("rst_htrans", HTRANS, 0);
        checkOutput("rst_haddr", HADDR, 0);
        checkOutput("rst_ack0", m0_ack, 0);
        checkOutput("rst_ack1", m1_ack, 0);
        checkOutput("hprot", HPROT, 4'b0011);
        HRESET = 1'b0;
        tick();

        // Single write from port 0, zero wait states.
        applyStimulus(0, 1'b1, 16'h2000, 1'b1, 3'd2, 32'h0000_0009);
        tick();
        checkOutput("t1_hsel", HSEL, 1);
        checkOutput("t1_htrans", HTRANS, 2'b10);
        checkOutput("t1_haddr", HADDR, 16'h2000);
        checkOutput("t1_hwrite", HWRITE, 1);
        checkOutput("t1_hsize", HSIZE, 2);
        tick();
        checkOutput("t1_htrans_data", HTRANS, 0);
        checkOutput("t1_hsel_data", HSEL, 0);
        checkOutput("t1_hwdata", HWDATA, 32'h9);
        checkOutput("t1_ack_early", m0_ack, 0);
        tick();
        checkOutput("t1_ack", m0_ack, 1);
        checkOutput("t1_err", m0_err, 0);
        checkOutput("t1_ack1", m1_ack, 0);
        applyStimulus(0, 1'b0, 16'h2000, 1'b1, 3'd2, 32'h0000_0009);
        tick();
        checkOutput("t1_ack_pulse", m0_ack, 0);

        // Read from port 1 with two wait states.
        applyStimulus(1, 1'b1, 16'h2004, 1'b0, 3'd2, 32'h0);
        tick();
        checkOutput("t2_haddr", HADDR, 16'h2004);
        checkOutput("t2_hwrite", HWRITE, 0);
        checkOutput("t2_htrans", HTRANS, 2'b10);
        HREADYOUT = 1'b0;
        tick();
        checkOutput("t2_htrans_data", HTRANS, 0);
        checkOutput("t2_hready", HREADY, 0);
        checkOutput("t2_ack_w1", m1_ack, 0);
        tick();
        checkOutput("t2_ack_w2", m1_ack, 0);
        tick();
        checkOutput("t2_ack_w3", m1_ack, 0);
        HREADYOUT = 1'b1; HRDATA = 32'h0000_0046;
        tick();
        checkOutput("t2_ack", m1_ack, 1);
        checkOutput("t2_rdata", m1_rdata, 32'h46);
        checkOutput("t2_err", m1_err, 0);
        checkOutput("t2_ack0", m0_ack, 0);
        checkOutput("t2_hready", HREADY, 1);
        applyStimulus(1, 1'b0, 16'h2004, 1'b0, 3'd2, 32'h0);
        HRDATA = '0;
        tick();
        checkOutput("t2_ack_pulse", m1_ack, 0);
        checkOutput("t2_rdata_hold", m1_rdata, 32'h46);

        // Simultaneous requests held high: grants alternate m0, m1, m0.
        applyStimulus(0, 1'b1, 16'h1C00, 1'b1, 3'd2, 32'h1ACC_E551);
        applyStimulus(1, 1'b1, 16'h1000, 1'b1, 3'd2, 32'h0000_005A);
        for (int i = 0; i < 11; i++) begin
            tick();
            checkOutput($sformatf("t3_htrans_%0d", i), HTRANS, t3Trans[i]);
            checkOutput($sformatf("t3_ack0_%0d", i), m0_ack, t3Ack0[i]);
            checkOutput($sformatf("t3_ack1_%0d", i), m1_ack, t3Ack1[i]);
            if (t3Trans[i] == 2'b10)
                checkOutput($sformatf("t3_haddr_%0d", i), HADDR, t3Addr[i]);
            if (i == 1 || i == 9)
                checkOutput($sformatf("t3_hwdata_%0d", i), HWDATA, 32'h1ACC_E551);
            if (i == 5)
                checkOutput($sformatf("t3_hwdata_%0d", i), HWDATA, 32'h5A);
        end
        applyStimulus(0, 1'b0, 16'h1C00, 1'b1, 3'd2, 32'h1ACC_E551);
        applyStimulus(1, 1'b0, 16'h1000, 1'b1, 3'd2, 32'h0000_005A);
        tick();

        // Two-cycle error response on port 0, then a normal read.
        applyStimulus(0, 1'b1, 16'h3000, 1'b1, 3'd2, 32'h77);
        tick();
        checkOutput("t4_haddr", HADDR, 16'h3000);
        checkOutput("t4_htrans", HTRANS, 2'b10);
        HREADYOUT = 1'b0; HRESP = 1'b1;
        tick();
        checkOutput("t4_ack_w1", m0_ack, 0);
        tick();
        checkOutput("t4_ack_w2", m0_ack, 0);
        HREADYOUT = 1'b1;
        tick();
        checkOutput("t4_ack", m0_ack, 1);
        checkOutput("t4_err", m0_err, 1);
        HRESP = 1'b0;
        applyStimulus(0, 1'b0, 16'h3000, 1'b1, 3'd2, 32'h77);
        tick();
        checkOutput("t4_ack_pulse", m0_ack, 0);
        checkOutput("t4_err_hold", m0_err, 1);
        applyStimulus(0, 1'b1, 16'h3004, 1'b0, 3'd2, 32'h0);
        HRDATA = 32'hABCD_1234;
        tick();
        checkOutput("t4b_haddr", HADDR, 16'h3004);
        checkOutput("t4b_hwrite", HWRITE, 0);
        tick();
        tick();
        checkOutput("t4b_ack", m0_ack, 1);
        checkOutput("t4b_err", m0_err, 0);
        checkOutput("t4b_rdata", m0_rdata, 32'hABCD_1234);
        applyStimulus(0, 1'b0, 16'h3004, 1'b0, 3'd2, 32'h0);
        HRDATA = '0;
        tick();

        // Reset during the data phase of a port 1 write.
        applyStimulus(1, 1'b1, 16'h1004, 1'b1, 3'd1, 32'h33);
        tick();
        checkOutput("t5_haddr", HADDR, 16'h1004);
        checkOutput("t5_hsize", HSIZE, 1);
        tick();
        checkOutput("t5_hwdata", HWDATA, 32'h33);
        HRESET = 1'b1; HREADYOUT = 1'b0;
        tick();
        checkOutput("t5_rst_hsel", HSEL, 0);
        checkOutput("t5_rst_htrans", HTRANS, 0);
        checkOutput("t5_rst_haddr", HADDR, 0);
        checkOutput("t5_rst_hwrite", HWRITE, 0);
        checkOutput("t5_rst_hsize", HSIZE, 0);
        checkOutput("t5_rst_hwdata", HWDATA, 0);
        checkOutput("t5_rst_ack0", m0_ack, 0);
        checkOutput("t5_rst_ack1", m1_ack, 0);
        checkOutput("t5_rst_err0", m0_err, 0);
        checkOutput("t5_rst_err1", m1_err, 0);
        checkOutput("t5_rst_rdata0", m0_rdata, 0);
        checkOutput("t5_rst_rdata1", m1_rdata, 0);
        HRESET = 1'b0; HREADYOUT = 1'b1;
        applyStimulus(0, 1'b1, 16'h2000, 1'b0, 3'd2, 32'h0);
        tick();
        checkOutput("t5_htrans", HTRANS, 2'b10);
        checkOutput("t5_win_haddr", HADDR, 16'h2000);
        checkOutput("t5_hwrite", HWRITE, 0);
        tick();
        checkOutput("t5_ack1_none", m1_ack, 0);
        tick();
        checkOutput("t5_ack0", m0_ack, 1);
        checkOutput("t5_ack1", m1_ack, 0);
        applyStimulus(0, 1'b0, 16'h2000, 1'b0, 3'd2, 32'h0);
        applyStimulus(1, 1'b0, 16'h1004, 1'b1, 3'd1, 32'h33);
        tick();
        tick();
        checkOutput("t5_idle_htrans", HTRANS, 0);
        checkOutput("t5_idle_ack1", m1_ack, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
